pwm_generator: RTL and testbench
================================

PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 The module SHALL take parameter WORD_LENGTH, default 8, as the width of duty_in and duty_onehot and as the number of steps per PWM period.
REQ-002 The module SHALL take parameter PRESCALE_WIDTH, default 16, as the width of prescale.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = RUN, 0 = IDLE.
REQ-006 prescale  input  PRESCALE_WIDTH  tick every prescale+1 clk cycles.
REQ-007 duty_valid  input  1  duty_in carries a new duty level.
REQ-008 duty_in  input  WORD_LENGTH  binary duty level, 0..WORD_LENGTH.
REQ-009 duty_ready  output  1  a duty level can be accepted this cycle.
REQ-010 pwm_out  output  1  registered PWM waveform.
REQ-011 period_end  output  1  one-cycle pulse on the last tick of a period.
REQ-012 duty_onehot  output  WORD_LENGTH  one-hot encoding of the active duty: level k sets bit k-1 only; level 0 is all zeros.

Function
REQ-013 A duty transfer SHALL occur only on a cycle where duty_valid and duty_ready are both 1.
REQ-014 Each transfer SHALL write duty_in, clamped to WORD_LENGTH when larger, into a shadow register and set the flag pending.
REQ-015 duty_ready SHALL equal NOT pending; a duty_valid seen while pending=1 SHALL be ignored.
REQ-016 The FSM SHALL have two states, IDLE and RUN.
REQ-017 In IDLE the FSM SHALL move to RUN on the cycle after enable=1; in RUN it SHALL move to IDLE on the cycle after enable=0, including mid-period.
REQ-018 In IDLE the prescale counter and step counter SHALL be held at 0, and pwm_out and period_end SHALL be 0.
REQ-019 In IDLE with pending=1, shadow SHALL be copied to active_duty and pending cleared on the next cycle.
REQ-020 In RUN the prescale counter SHALL count 0..prescale and raise tick when it equals prescale, then wrap to 0; prescale=0 SHALL give a tick every cycle.
REQ-021 A prescale change during RUN SHALL take effect at the next counter compare.
REQ-022 The step counter SHALL advance on each tick, counting 0..WORD_LENGTH-1 and wrapping to 0.
REQ-023 The period boundary SHALL be a tick while the step counter equals WORD_LENGTH-1.
REQ-024 At the period boundary, period_end SHALL pulse high for exactly one cycle.
REQ-025 At the period boundary with pending=1, shadow SHALL be copied to active_duty and pending cleared, so duty never changes mid-period.
REQ-026 In RUN, pwm_out SHALL be (step counter < active_duty), registered with one cycle of latency.
REQ-027 Duty level 0 SHALL give a constant-low pwm_out; duty level WORD_LENGTH SHALL give a constant-high pwm_out.
REQ-028 duty_onehot SHALL be registered and follow active_duty one cycle after each update.
REQ-029 A transfer on the same cycle as the boundary is possible only when pending=0; the new value SHALL then take effect at the following boundary.

Reset
REQ-030 While reset=1, the FSM SHALL be in IDLE and both counters, shadow, active_duty and pending SHALL be 0.
REQ-031 While reset=1, pwm_out=0, period_end=0, duty_onehot=0 and duty_ready=1 from the first cycle with reset high.
REQ-032 Reset SHALL take priority over enable and duty_valid.
REQ-033 Reset mid-period SHALL discard a pending duty.

Structure
REQ-034 The FSM state enum (IDLE, RUN) and the default WORD_LENGTH SHALL be defined in a shared package, pwm_pkg.
REQ-035 The binary-to-one-hot conversion SHALL be a sub-module, duty_encoder: purely combinational, with clamping applied before it.
REQ-036 The prescaler, step counter, FSM and duty registers SHALL reside in pwm_generator.

Verification
REQ-037 Reset: after reset, enable=1 and prescale=0 with no load -> pwm_out stays 0, period_end every 8 cycles, duty_onehot=8'h00.
REQ-038 Duty 3, prescale 0, RUN -> pwm_out high 3 cycles and low 5 per 8-cycle period; duty_onehot=8'b00000100.
REQ-039 Duty 2 active, duty 6 loaded at step 4 -> period completes at 2/8; the next period runs at 6/8; duty_ready is 0 from the load until the boundary.
REQ-040 prescale=2, duty 8 -> pwm_out constant 1; period_end once every 24 cycles.
REQ-041 duty_in=12 -> clamps to 8, duty_onehot=8'b10000000; a second duty_valid while pending is ignored.
REQ-042 enable dropped at step 5 -> next cycle IDLE: pwm_out=0, counters 0; re-enable restarts the period at step 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: FSM state type, default sizes
// and a helper for sizing the step counter.
package pwm_pkg;

    localparam int DEFAULT_WORD_LENGTH    = 8;
    localparam int DEFAULT_PRESCALE_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

    // Bits needed to count 0..words-1, never less than one bit.
    function automatic int stepWidth(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/duty_encoder.sv
// Binary duty level to one-hot: level k lights bit k-1, level 0 lights
// nothing. Purely combinational; the caller clamps the level beforehand.
module duty_encoder
    import pwm_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic [WORD_LENGTH-1:0] level_i,
    output logic [WORD_LENGTH-1:0] onehot_o
);

    // Each output bit is a simple equality compare against its own level.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            onehot_o[i] = (level_i == WORD_LENGTH'(i + 1));
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator: prescaled step counter, IDLE/RUN control, and a
// shadow/active duty pair so that a new duty level only takes effect at a
// period boundary (or immediately while idle).
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WORD_LENGTH    = DEFAULT_WORD_LENGTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      duty_valid,
    input  logic [WORD_LENGTH-1:0]    duty_in,
    output logic                      duty_ready,
    output logic                      pwm_out,
    output logic                      period_end,
    output logic [WORD_LENGTH-1:0]    duty_onehot
);

    localparam int STEP_W = stepWidth(WORD_LENGTH);
    localparam logic [STEP_W-1:0]      LAST_STEP = STEP_W'(WORD_LENGTH - 1);
    localparam logic [WORD_LENGTH-1:0] MAX_DUTY  = WORD_LENGTH'(WORD_LENGTH);

    pwm_state_e                state_q,      state_d;
    logic [PRESCALE_WIDTH-1:0] presCount_q,  presCount_d;
    logic [STEP_W-1:0]         stepCount_q,  stepCount_d;
    logic [WORD_LENGTH-1:0]    shadowDuty_q, shadowDuty_d;
    logic [WORD_LENGTH-1:0]    activeDuty_q, activeDuty_d;
    logic                      pending_q,    pending_d;
    logic                      pwmOut_q,     pwmOut_d;
    logic                      periodEnd_q,  periodEnd_d;
    logic [WORD_LENGTH-1:0]    dutyOnehot_q, dutyOnehot_d;

    logic                      tick;
    logic                      boundary;
    logic                      transfer;
    logic                      loadActive;
    logic [WORD_LENGTH-1:0]    clampedDuty;
    logic [WORD_LENGTH-1:0]    stepWide;

    // Using >= rather than == means a prescale lowered below the running
    // count still produces a tick at the next compare instead of wrapping.
    assign tick        = (state_q == RUN) && (presCount_q >= prescale);
    assign boundary    = tick && (stepCount_q == LAST_STEP);
    assign transfer    = duty_valid && !pending_q;
    assign loadActive  = pending_q && ((state_q == IDLE) || boundary);
    assign clampedDuty = (duty_in > MAX_DUTY) ? MAX_DUTY : duty_in;
    assign stepWide    = WORD_LENGTH'(stepCount_q);

    duty_encoder #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_encoder (
        .level_i  (activeDuty_q),
        .onehot_o (dutyOnehot_d)
    );

    // Next-state logic: FSM, counters, registered outputs and the duty
    // handshake. Outputs are forced low whenever the next state is IDLE.
    always_comb begin
        state_d      = state_q;
        presCount_d  = '0;
        stepCount_d  = '0;
        pwmOut_d     = 1'b0;
        periodEnd_d  = 1'b0;
        shadowDuty_d = shadowDuty_q;
        activeDuty_d = activeDuty_q;
        pending_d    = pending_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    presCount_d = tick ? '0 : presCount_q + PRESCALE_WIDTH'(1);
                    if (tick) begin
                        stepCount_d = (stepCount_q == LAST_STEP) ? '0
                                    : stepCount_q + STEP_W'(1);
                    end else begin
                        stepCount_d = stepCount_q;
                    end
                    pwmOut_d    = (stepWide < activeDuty_q);
                    periodEnd_d = boundary;
                end
            end
            default: state_d = IDLE;
        endcase

        // transfer needs pending=0 and loadActive needs pending=1, so at
        // most one of these fires in any cycle.
        if (transfer) begin
            shadowDuty_d = clampedDuty;
            pending_d    = 1'b1;
        end else if (loadActive) begin
            activeDuty_d = shadowDuty_q;
            pending_d    = 1'b0;
        end
    end

    // State register with synchronous reset; reset discards any pending duty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            presCount_q  <= '0;
            stepCount_q  <= '0;
            shadowDuty_q <= '0;
            activeDuty_q <= '0;
            pending_q    <= 1'b0;
            pwmOut_q     <= 1'b0;
            periodEnd_q  <= 1'b0;
            dutyOnehot_q <= '0;
        end else begin
            state_q      <= state_d;
            presCount_q  <= presCount_d;
            stepCount_q  <= stepCount_d;
            shadowDuty_q <= shadowDuty_d;
            activeDuty_q <= activeDuty_d;
            pending_q    <= pending_d;
            pwmOut_q     <= pwmOut_d;
            periodEnd_q  <= periodEnd_d;
            dutyOnehot_q <= dutyOnehot_d;
        end
    end

    assign duty_ready  = !pending_q;
    assign pwm_out     = pwmOut_q;
    assign period_end  = periodEnd_q;
    assign duty_onehot = dutyOnehot_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: a fixed vector table, a few hand-built
// multi-cycle sequences, then randomized traffic against a reference model
// that derives step and period position from elapsed run cycles.
module tb_pwm_generator;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [15:0] prescale;
    logic       dutyValid;
    logic [7:0] dutyIn;
    logic       dutyReady;
    logic       pwmOut;
    logic       periodEnd;
    logic [7:0] dutyOnehot;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         mRun;
    int         mN;
    int         mShadow;
    int         mActive;
    bit         mPending;
    bit         mPwm;
    bit         mPe;
    logic [7:0] mOh;

    typedef struct {
        logic       rst;
        logic       en;
        logic [15:0] pre;
        logic       vld;
        logic [7:0] din;
        logic       pwm;
        logic       pe;
        logic [7:0] oh;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    pwm_generator #(
        .WORD_LENGTH    (W),
        .PRESCALE_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .prescale    (prescale),
        .duty_valid  (dutyValid),
        .duty_in     (dutyIn),
        .duty_ready  (dutyReady),
        .pwm_out     (pwmOut),
        .period_end  (periodEnd),
        .duty_onehot (dutyOnehot)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Model of one clock edge, built from elapsed cycles since entering RUN:
    // step = (n / (prescale+1)) % W, boundary on the last cycle of each
    // W*(prescale+1)-cycle period.
    task automatic modelStep();
        int  p1;
        int  periodLen;
        bit  bnd;
        bit  load;
        if (reset) begin
            mRun = 0; mN = 0; mShadow = 0; mActive = 0; mPending = 0;
            mPwm = 0; mPe = 0; mOh = 8'h00;
            return;
        end
        p1        = int'(prescale) + 1;
        periodLen = W * p1;
        mOh  = (mActive == 0) ? 8'h00 : 8'(1 << (mActive - 1));
        bnd  = mRun && ((mN % periodLen) == periodLen - 1);
        load = mPending && (!mRun || bnd);
        if (mRun && enable) begin
            mPwm = (((mN / p1) % W) < mActive);
            mPe  = bnd;
            mN   = mN + 1;
        end else begin
            mPwm = 0;
            mPe  = 0;
            mN   = 0;
        end
        mRun = enable;
        if (dutyValid && !mPending) begin
            mShadow  = (int'(dutyIn) > W) ? W : int'(dutyIn);
            mPending = 1;
        end else if (load) begin
            mActive  = mShadow;
            mPending = 0;
        end
    endtask

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic pwm, input logic pe,
                               input logic [7:0] oh, input logic rdy);
        checkOne({name, ".pwm_out"},     32'(pwmOut),     32'(pwm));
        checkOne({name, ".period_end"},  32'(periodEnd),  32'(pe));
        checkOne({name, ".duty_onehot"}, 32'(dutyOnehot), 32'(oh));
        checkOne({name, ".duty_ready"},  32'(dutyReady),  32'(rdy));
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mPwm, mPe, mOh, !mPending);
    endtask

    // Drive inputs (called at a falling edge), step the model at the rising
    // edge, and return at the next falling edge ready for sampling.
    task automatic applyStimulus(input logic r, input logic e, input logic [15:0] p,
                                 input logic v, input logic [7:0] d);
        reset     = r;
        enable    = e;
        prescale  = p;
        dutyValid = v;
        dutyIn    = d;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [7:0] d,
                                input logic pwm, input logic pe, input logic [7:0] oh,
                                input logic rdy);
        vec_t t;
        t.rst = r; t.en = e; t.pre = 16'd0; t.vld = v; t.din = d;
        t.pwm = pwm; t.pe = pe; t.oh = oh; t.rdy = rdy;
        return t;
    endfunction

    initial begin
        int trace[16];
        int cnt;
        int cntB;
        logic rEn;
        logic [15:0] rPre;

        // Table: reset, load duty 3 while idle, run one period plus one step,
        // stop, clamp 12 -> 8 with a second ignored offer, restart, reset
        // overriding enable and duty_valid.
        vecs.push_back(mk(1, 0, 0, 8'd0,  0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 8'd3,  0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'd0,  0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 0, 8'd0,  0, 0, 8'h04, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 8'd0, 1, 0, 8'h04, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 8'h04, 1));
        vecs.push_back(mk(0, 1, 0, 8'd0,  0, 1, 8'h04, 1));
        vecs.push_back(mk(0, 1, 0, 8'd0,  1, 0, 8'h04, 1));
        vecs.push_back(mk(0, 0, 0, 8'd0,  0, 0, 8'h04, 1));
        vecs.push_back(mk(0, 0, 0, 8'd0,  0, 0, 8'h04, 1));
        vecs.push_back(mk(0, 0, 1, 8'd12, 0, 0, 8'h04, 0));
        vecs.push_back(mk(0, 0, 1, 8'd5,  0, 0, 8'h04, 1));
        vecs.push_back(mk(0, 0, 0, 8'd0,  0, 0, 8'h80, 1));
        vecs.push_back(mk(0, 1, 0, 8'd0,  0, 0, 8'h80, 1));
        vecs.push_back(mk(0, 1, 0, 8'd0,  1, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 1, 8'd7,  0, 0, 8'h00, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].pre, vecs[i].vld, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].pwm, vecs[i].pe, vecs[i].oh, vecs[i].rdy);
        end

        // Reset with enable and no duty load: constant low, period_end every 8.
        applyStimulus(1, 0, 16'd0, 0, 8'd0); checkModel("rst37");
        applyStimulus(0, 1, 16'd0, 0, 8'd0); checkModel("en37");
        cnt = 0;
        cntB = 0;
        for (int n = 0; n < 16; n++) begin
            applyStimulus(0, 1, 16'd0, 0, 8'd0);
            checkModel($sformatf("nodut%0d", n));
            cnt  += int'(periodEnd);
            cntB += int'(pwmOut);
        end
        checkOne("nodut period_end count", 32'(cnt), 32'd2);
        checkOne("nodut pwm high count", 32'(cntB), 32'd0);

        // Duty 2 active, duty 6 offered at step 4: switch only at the boundary.
        applyStimulus(1, 0, 16'd0, 0, 8'd0); checkModel("rst39");
        applyStimulus(0, 0, 16'd0, 1, 8'd2); checkModel("load2");
        applyStimulus(0, 0, 16'd0, 0, 8'd0); checkModel("idle39");
        applyStimulus(0, 1, 16'd0, 0, 8'd0); checkModel("en39");
        for (int n = 0; n < 16; n++) begin
            applyStimulus(0, 1, 16'd0, n == 4, 8'd6);
            checkModel($sformatf("swap%0d", n));
            trace[n] = int'(pwmOut);
            if (n >= 4 && n <= 6) checkOne($sformatf("ready low n%0d", n), 32'(dutyReady), 32'd0);
            if (n == 7) checkOne("ready after boundary", 32'(dutyReady), 32'd1);
        end
        cnt = 0;
        cntB = 0;
        for (int n = 0; n < 8; n++) begin
            cnt  += trace[n];
            cntB += trace[n + 8];
        end
        checkOne("duty2 period highs", 32'(cnt), 32'd2);
        checkOne("duty6 period highs", 32'(cntB), 32'd6);

        // Prescale 2, duty 8: constant high, period_end once per 24 cycles.
        applyStimulus(1, 0, 16'd2, 0, 8'd0); checkModel("rst40");
        applyStimulus(0, 0, 16'd2, 1, 8'd8); checkModel("load8");
        applyStimulus(0, 0, 16'd2, 0, 8'd0); checkModel("idle40");
        applyStimulus(0, 1, 16'd2, 0, 8'd0); checkModel("en40");
        cnt = 0;
        cntB = 0;
        for (int n = 0; n < 48; n++) begin
            applyStimulus(0, 1, 16'd2, 0, 8'd0);
            checkModel($sformatf("full%0d", n));
            cnt  += int'(periodEnd);
            cntB += int'(pwmOut);
        end
        checkOne("presc2 period_end count", 32'(cnt), 32'd2);
        checkOne("presc2 pwm high count", 32'(cntB), 32'd48);

        // Enable dropped at step 5, then restart from step 0.
        applyStimulus(1, 0, 16'd0, 0, 8'd0); checkModel("rst42");
        applyStimulus(0, 0, 16'd0, 1, 8'd3); checkModel("load3");
        applyStimulus(0, 0, 16'd0, 0, 8'd0); checkModel("idle42");
        applyStimulus(0, 1, 16'd0, 0, 8'd0); checkModel("en42");
        for (int n = 0; n < 5; n++) begin
            applyStimulus(0, 1, 16'd0, 0, 8'd0);
            checkModel($sformatf("pre%0d", n));
        end
        applyStimulus(0, 0, 16'd0, 0, 8'd0);
        checkOutput("drop at step5", 0, 0, 8'h04, 1);
        applyStimulus(0, 0, 16'd0, 0, 8'd0); checkModel("idle42b");
        applyStimulus(0, 1, 16'd0, 0, 8'd0); checkModel("reen42");
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            applyStimulus(0, 1, 16'd0, 0, 8'd0);
            checkModel($sformatf("restart%0d", n));
            if (n == 0) checkOne("restart step0 high", 32'(pwmOut), 32'd1);
            cnt += int'(pwmOut);
        end
        checkOne("restart period highs", 32'(cnt), 32'd3);

        // Randomized traffic; prescale only changes while fully idle.
        applyStimulus(1, 0, 16'd0, 0, 8'd0); checkModel("rstRand");
        rEn  = 1'b0;
        rPre = 16'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(29) == 0) rEn = ~rEn;
            if (!rEn && !mRun) rPre = 16'($urandom_range(3));
            applyStimulus($urandom_range(199) == 0, rEn, rPre,
                          $urandom_range(5) == 0, 8'($urandom_range(15)));
            checkModel($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
